demux13x16_buf: RTL and testbench
=================================

// Module: demux13x16_buf
// PURPOSE
//  1-to-3 distributor for 16-bit words: the inverse of the 3:1 word mux.
//  Accepts one word plus a 2-bit select per handshake and steers it into one
//  of three single-entry output buffers (channels A, B, C).
//  Each channel drains independently through its own valid/ready handshake.
//  Sits between a shared datapath result bus and three consumer stages.
// PARAMETERS
//  WIDTH   16  data width of every port and buffer
//  CNTW    16  width of each per-channel delivered-word counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_data    in   WIDTH  word to distribute
//  in_sel     in   2      destination: 00=A, 01=B, 1x=C
//  in_valid   in   1      in_data/in_sel are valid
//  in_ready   out  1      a word is accepted this cycle when in_valid&in_ready
//  a_data     out  WIDTH  channel A buffered word
//  a_valid    out  1      channel A buffer full
//  a_ready    in   1      channel A consumer takes the word
//  b_data     out  WIDTH  channel B buffered word
//  b_valid    out  1      channel B buffer full
//  b_ready    in   1      channel B consumer takes the word
//  c_data     out  WIDTH  channel C buffered word
//  c_valid    out  1      channel C buffer full
//  c_ready    in   1      channel C consumer takes the word
//  a_cnt      out  CNTW   words delivered on A (a_valid&a_ready)
//  b_cnt      out  CNTW   words delivered on B
//  c_cnt      out  CNTW   words delivered on C
// BEHAVIOUR
//  - Reset (rst_n=0, async): all *_valid=0, all *_data=0, all *_cnt=0.
//    A word held in a buffer is discarded; a counter never counts it.
//  - Per-channel buffer FSM, 2 states: EMPTY, FULL.
//    EMPTY -> FULL on accept targeting the channel.
//    FULL -> EMPTY on x_valid&x_ready with no new accept for that channel.
//    FULL stays FULL, data replaced, on drain and accept in the same cycle.
//  - in_ready is combinational on in_sel: ready = !x_valid | x_ready for the
//    selected channel x. There is no path from in_valid to in_ready.
//  - Latency: the word appears on x_data with x_valid=1 in the cycle after
//    acceptance. Throughput is 1 word/cycle per channel when the consumer is
//    always ready.
//  - Only the selected channel changes on accept. Other channels hold data and
//    valid unless they drain in the same cycle.
//  - x_data is stable while x_valid=1 and x_ready=0.
//    x_data keeps its last value after drain; it is not cleared.
//  - in_sel=2'b11 routes to C, identical to 2'b10.
//  - Counters add 1 per delivered word and wrap from 2^CNTW-1 to 0.
//    All three may count in the same cycle.
//  - Order is preserved within a channel. No ordering across channels.
// TESTING
//  - Reset: hold rst_n=0 mid-transfer -> all valid=0, data=0, cnt=0 at once,
//    without waiting for a clock edge.
//  - Route: send 16'h1234/00, 16'hBEEF/01, 16'h0F0F/10, all readies=1
//    -> A=1234, B=BEEF, C=0F0F each one cycle after accept; cnt each =1.
//  - Backpressure: a_ready=0, send 16'hAAAA then 16'h5555 to A
//    -> in_ready=0 on the 2nd word and a_data holds AAAA.
//    Then a_ready=1 -> AAAA delivered, 5555 accepted in the same cycle.
//  - Independence: A stalled and full, send 16'h7777/01 -> accepted at once,
//    b_valid=1 next cycle, A unchanged.
//  - Alias: in_sel=11 with 16'hC0DE -> c_valid=1, c_data=C0DE, a/b untouched.
//  - Wrap: preload traffic to 65535 deliveries on B, one more -> b_cnt=0.

Source files
------------

// File: rtl/demux13x16_buf.sv
// 1-to-3 word distributor: steers each accepted word into one of three single-entry
// channel buffers (A, B, C), each drained by its own valid/ready handshake.
module demux13x16_buf #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] c_data,
    output logic             c_valid,
    input  logic             c_ready,
    output logic [CNTW-1:0]  a_cnt,
    output logic [CNTW-1:0]  b_cnt,
    output logic [CNTW-1:0]  c_cnt
);

    localparam int unsigned NumCh = 3;

    typedef enum logic {StEmpty, StFull} buf_state_e;

    buf_state_e             state_q [NumCh];
    buf_state_e             state_d [NumCh];
    logic [WIDTH-1:0]       data_q  [NumCh];
    logic [CNTW-1:0]        cnt_q   [NumCh];

    logic [NumCh-1:0]       sel_oh;
    logic [NumCh-1:0]       ready_vec;
    logic [NumCh-1:0]       valid_vec;
    logic [NumCh-1:0]       accept;
    logic [NumCh-1:0]       drain;

    assign ready_vec = {c_ready, b_ready, a_ready};

    // Both 2'b10 and 2'b11 address channel C.
    always_comb begin
        sel_oh = '0;
        unique case (in_sel)
            2'b00:   sel_oh = 3'b001;
            2'b01:   sel_oh = 3'b010;
            default: sel_oh = 3'b100;
        endcase
    end

    // in_ready depends only on in_sel and the selected buffer, never on in_valid.
    assign in_ready = |(sel_oh & (~valid_vec | ready_vec));
    assign accept   = sel_oh & {NumCh{in_valid & in_ready}};
    assign drain    = valid_vec & ready_vec;

    // Buffer FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumCh; i++) begin
                state_q[i] <= StEmpty;
            end
        end else begin
            for (int i = 0; i < NumCh; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Buffer FSM: next state.
    always_comb begin
        for (int i = 0; i < NumCh; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                StEmpty: begin
                    if (accept[i]) state_d[i] = StFull;
                end
                StFull: begin
                    if (drain[i] && !accept[i]) state_d[i] = StEmpty;
                end
                default: state_d[i] = StEmpty;
            endcase
        end
    end

    // Buffer FSM: outputs.
    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < NumCh; i++) begin
            valid_vec[i] = (state_q[i] == StFull);
        end
    end

    // Data is loaded only on accept, so it holds under stall and persists after drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumCh; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumCh; i++) begin
                if (accept[i]) data_q[i] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumCh; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumCh; i++) begin
                if (drain[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    assign a_data  = data_q[0];
    assign b_data  = data_q[1];
    assign c_data  = data_q[2];
    assign a_valid = valid_vec[0];
    assign b_valid = valid_vec[1];
    assign c_valid = valid_vec[2];
    assign a_cnt   = cnt_q[0];
    assign b_cnt   = cnt_q[1];
    assign c_cnt   = cnt_q[2];

endmodule

// File: tb/tb_demux13x16_buf.sv
// Bench for demux13x16_buf: directed vector table, async-reset and counter-wrap sequences,
// and randomized traffic checked against a per-channel occupancy model.
module tb_demux13x16_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_data, b_data, c_data;
    logic        a_valid, b_valid, c_valid;
    logic        a_ready, b_ready, c_ready;
    logic [15:0] a_cnt, b_cnt, c_cnt;

    int errors = 0;
    int checks = 0;

    demux13x16_buf #(.WIDTH(16), .CNTW(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .c_data   (c_data),
        .c_valid  (c_valid),
        .c_ready  (c_ready),
        .a_cnt    (a_cnt),
        .b_cnt    (b_cnt),
        .c_cnt    (c_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel holds at most one word; counters count deliveries.
    bit          m_full [3];
    logic [15:0] m_data [3];
    int unsigned m_cnt  [3];

    function automatic int ch_of(input logic [1:0] s);
        if (s == 2'd0) return 0;
        if (s == 2'd1) return 1;
        return 2;
    endfunction

    function automatic bit rdy_of(input int c);
        if (c == 0) return a_ready;
        if (c == 1) return b_ready;
        return c_ready;
    endfunction

    function automatic bit m_in_ready();
        int c = ch_of(in_sel);
        return !m_full[c] || rdy_of(c);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_full[c] = 0;
            m_data[c] = '0;
            m_cnt[c]  = 0;
        end
    endtask

    task automatic model_edge();
        bit acc_any = in_valid && m_in_ready();
        int tgt     = ch_of(in_sel);
        for (int c = 0; c < 3; c++) begin
            bit dr  = m_full[c] && rdy_of(c);
            bit acc = acc_any && (tgt == c);
            if (dr) m_cnt[c] = (m_cnt[c] + 1) % 65536;
            m_full[c] = acc || (m_full[c] && !dr);
            if (acc) m_data[c] = in_data;
        end
    endtask

    task automatic check_model();
        chk("in_ready", 16'(in_ready), 16'(m_in_ready()));
        chk("a_valid", 16'(a_valid), 16'(m_full[0]));
        chk("b_valid", 16'(b_valid), 16'(m_full[1]));
        chk("c_valid", 16'(c_valid), 16'(m_full[2]));
        chk("a_data", a_data, m_data[0]);
        chk("b_data", b_data, m_data[1]);
        chk("c_data", c_data, m_data[2]);
        chk("a_cnt", a_cnt, 16'(m_cnt[0]));
        chk("b_cnt", b_cnt, 16'(m_cnt[1]));
        chk("c_cnt", c_cnt, 16'(m_cnt[2]));
    endtask

    // Called just after an active edge; returns 1 time unit after the next edge.
    task automatic step(input bit do_check);
        @(negedge clk);
        if (do_check) check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  s;
        logic [15:0] d;
        logic [2:0]  r;    // {a_ready, b_ready, c_ready}
        logic        ir;
        logic [2:0]  ev;   // {a_valid, b_valid, c_valid}
        logic [15:0] ea, eb, ec;
        logic [15:0] ca, cb, cc;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // Route, backpressure, independence and alias, one row per cycle.
        vecs[0]  = '{1'b1, 2'd0, 16'h1234, 3'b111, 1'b1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 16'd0, 16'd0, 16'd0};
        vecs[1]  = '{1'b1, 2'd1, 16'hBEEF, 3'b111, 1'b1, 3'b100, 16'h1234, 16'h0000, 16'h0000, 16'd0, 16'd0, 16'd0};
        vecs[2]  = '{1'b1, 2'd2, 16'h0F0F, 3'b111, 1'b1, 3'b010, 16'h1234, 16'hBEEF, 16'h0000, 16'd1, 16'd0, 16'd0};
        vecs[3]  = '{1'b0, 2'd0, 16'h0000, 3'b111, 1'b1, 3'b001, 16'h1234, 16'hBEEF, 16'h0F0F, 16'd1, 16'd1, 16'd0};
        vecs[4]  = '{1'b1, 2'd0, 16'hAAAA, 3'b011, 1'b1, 3'b000, 16'h1234, 16'hBEEF, 16'h0F0F, 16'd1, 16'd1, 16'd1};
        vecs[5]  = '{1'b1, 2'd0, 16'h5555, 3'b011, 1'b0, 3'b100, 16'hAAAA, 16'hBEEF, 16'h0F0F, 16'd1, 16'd1, 16'd1};
        vecs[6]  = '{1'b1, 2'd1, 16'h7777, 3'b011, 1'b1, 3'b100, 16'hAAAA, 16'hBEEF, 16'h0F0F, 16'd1, 16'd1, 16'd1};
        vecs[7]  = '{1'b1, 2'd0, 16'h5555, 3'b011, 1'b0, 3'b110, 16'hAAAA, 16'h7777, 16'h0F0F, 16'd1, 16'd1, 16'd1};
        vecs[8]  = '{1'b1, 2'd0, 16'h5555, 3'b111, 1'b1, 3'b100, 16'hAAAA, 16'h7777, 16'h0F0F, 16'd1, 16'd2, 16'd1};
        vecs[9]  = '{1'b1, 2'd3, 16'hC0DE, 3'b010, 1'b1, 3'b100, 16'h5555, 16'h7777, 16'h0F0F, 16'd2, 16'd2, 16'd1};
        vecs[10] = '{1'b0, 2'd0, 16'h0000, 3'b000, 1'b0, 3'b101, 16'h5555, 16'h7777, 16'hC0DE, 16'd2, 16'd2, 16'd1};
        vecs[11] = '{1'b0, 2'd2, 16'h0000, 3'b101, 1'b1, 3'b101, 16'h5555, 16'h7777, 16'hC0DE, 16'd2, 16'd2, 16'd1};
        vecs[12] = '{1'b0, 2'd0, 16'h0000, 3'b111, 1'b1, 3'b000, 16'h5555, 16'h7777, 16'hC0DE, 16'd3, 16'd2, 16'd2};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 2'd0;
        in_data  = '0;
        {a_ready, b_ready, c_ready} = 3'b000;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            in_valid = vecs[i].v;
            in_sel   = vecs[i].s;
            in_data  = vecs[i].d;
            {a_ready, b_ready, c_ready} = vecs[i].r;
            @(negedge clk);
            chk($sformatf("vec%0d in_ready", i), 16'(in_ready), 16'(vecs[i].ir));
            chk($sformatf("vec%0d valids", i), 16'({a_valid, b_valid, c_valid}), 16'(vecs[i].ev));
            chk($sformatf("vec%0d a_data", i), a_data, vecs[i].ea);
            chk($sformatf("vec%0d b_data", i), b_data, vecs[i].eb);
            chk($sformatf("vec%0d c_data", i), c_data, vecs[i].ec);
            chk($sformatf("vec%0d a_cnt", i), a_cnt, vecs[i].ca);
            chk($sformatf("vec%0d b_cnt", i), b_cnt, vecs[i].cb);
            chk($sformatf("vec%0d c_cnt", i), c_cnt, vecs[i].cc);
            @(posedge clk);
            #1;
        end

        // Fill all three buffers under stall, then assert reset between edges.
        {a_ready, b_ready, c_ready} = 3'b000;
        in_valid = 1'b1;
        in_sel = 2'd0; in_data = 16'h1111; @(posedge clk); #1;
        in_sel = 2'd1; in_data = 16'h2222; @(posedge clk); #1;
        in_sel = 2'd2; in_data = 16'h3333; @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst valids", 16'({a_valid, b_valid, c_valid}), 16'h0007);
        chk("pre_rst a_data", a_data, 16'h1111);
        #2 rst_n = 1'b0;
        #1;
        chk("rst valids", 16'({a_valid, b_valid, c_valid}), 16'h0000);
        chk("rst a_data", a_data, 16'h0000);
        chk("rst b_data", b_data, 16'h0000);
        chk("rst c_data", c_data, 16'h0000);
        chk("rst a_cnt", a_cnt, 16'h0000);
        chk("rst b_cnt", b_cnt, 16'h0000);
        chk("rst c_cnt", c_cnt, 16'h0000);
        {a_ready, b_ready, c_ready} = 3'b111;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        chk("post_rst a_cnt", a_cnt, 16'h0000);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 2'($urandom_range(0, 3));
            in_data  = 16'($urandom);
            a_ready  = ($urandom_range(0, 2) != 0);
            b_ready  = ($urandom_range(0, 2) != 0);
            c_ready  = ($urandom_range(0, 3) == 0);
            step(1'b1);
        end

        // Counter wrap on B: 65535 deliveries, then one more.
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b1;
        in_sel   = 2'd1;
        {a_ready, b_ready, c_ready} = 3'b111;
        for (int n = 0; n < 65536; n++) begin
            in_data = 16'(n);
            step(1'b0);
        end
        chk("wrap b_cnt max", b_cnt, 16'hFFFF);
        chk("wrap b_valid", 16'(b_valid), 16'h0001);
        in_valid = 1'b0;
        step(1'b0);
        chk("wrap b_cnt zero", b_cnt, 16'h0000);
        chk("wrap a_cnt", a_cnt, 16'h0000);
        step(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
